// File: rtl/display_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : display_scan_ctrl_if
// Purpose  : Bundles the load handshake, display controls and the multiplexed
//            7-segment outputs of display_scan_ctrl.
// Signals  : load_valid/load_ready/digits_in - shadow-buffer load port
//            bright, dig_en                  - brightness level, digit mask
//            segmentos, sel_seg, frame_tick  - display bus and frame strobe
// Modports : master - the side that loads codes and drives the display
//            slave  - the scan controller itself
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface display_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] digits_in;
  logic [3:0]  bright;
  logic [3:0]  dig_en;
  logic [7:0]  segmentos;
  logic [3:0]  sel_seg;
  logic        frame_tick;

  modport master (
    output load_valid, digits_in, bright, dig_en,
    input  load_ready, segmentos, sel_seg, frame_tick
  );

  modport slave (
    input  load_valid, digits_in, bright, dig_en,
    output load_ready, segmentos, sel_seg, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : display_scan_ctrl
// Purpose  : Scan scheduler for a 4-digit multiplexed 7-segment display.
//            Double-buffers four segment codes and time-shares the segment bus
//            across the anodes with a fixed dwell per digit, a blank interval
//            at slot start, 16-level brightness PWM and a per-digit mask.
// Ports    : clk - system clock
//            rst - synchronous reset, active-low
//            bus - display_scan_ctrl_if.slave (load port, controls, outputs)
// Params   : DWELL_CYC - cycles per digit slot (> BLANK_CYC)
//            BLANK_CYC - all-anodes-off cycles at slot start (>= 1)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl #(
  parameter int DWELL_CYC = 12500,
  parameter int BLANK_CYC = 250
) (
  input  wire logic        clk,
  input  wire logic        rst,
  display_scan_ctrl_if.slave bus
);

  localparam int                 c_cnt_w      = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(DWELL_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_dig;
  logic [3:0]           r_pwm;
  logic [31:0]          r_active;
  logic [31:0]          r_shadow;
  logic                 r_full;
  logic [7:0]           r_seg;
  logic [3:0]           r_sel;
  logic                 r_tick;

  logic                 w_slot_end;
  logic                 w_boundary;
  logic                 w_accept;
  logic                 w_lit;
  logic [7:0]           w_seg_nxt;
  logic [3:0]           w_sel_nxt;
  logic                 w_tick_nxt;

  assign w_slot_end = (r_cnt == c_cnt_last);
  assign w_boundary = w_slot_end && (r_dig == 2'd3);
  assign w_accept   = bus.load_valid && !r_full;
  assign w_tick_nxt = (r_dig == 2'd0) && (r_cnt == '0);

  // Slot phase FSM and the lit decision for the output registers.
  always_comb begin
    w_state_nxt = r_state;
    w_lit       = 1'b0;
    w_seg_nxt   = 8'hFF;
    w_sel_nxt   = 4'hF;
    case (r_state)
      ST_BLANK: begin
        if (w_slot_end) begin
          w_state_nxt = ST_BLANK;
        end else if (r_cnt == c_blank_last) begin
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // pwm runs free across slots, so the duty pattern is not re-phased per digit.
        w_lit = bus.dig_en[r_dig] && (r_pwm <= bus.bright);
        if (w_slot_end) begin
          w_state_nxt = ST_BLANK;
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
    if (w_lit) begin
      w_sel_nxt = ~(4'b0001 << r_dig);
      w_seg_nxt = r_active[{r_dig, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_BLANK;
      r_cnt    <= '0;
      r_dig    <= 2'd0;
      r_pwm    <= 4'd0;
      r_active <= 32'hFFFF_FFFF;
      r_shadow <= 32'hFFFF_FFFF;
      r_full   <= 1'b0;
      r_seg    <= 8'hFF;
      r_sel    <= 4'hF;
      r_tick   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_slot_end ? '0 : r_cnt + c_cnt_w'(1);
      if (w_slot_end) begin
        r_dig <= r_dig + 2'd1;
      end
      r_pwm <= r_pwm + 4'd1;

      // Transfer and accept are mutually exclusive: transfer needs a full
      // shadow, accept needs an empty one. A load landing in the boundary
      // cycle therefore waits in the shadow for the following frame.
      if (w_boundary && r_full) begin
        r_active <= r_shadow;
        r_full   <= 1'b0;
      end else if (w_accept) begin
        r_shadow <= bus.digits_in;
        r_full   <= 1'b1;
      end

      r_seg  <= w_seg_nxt;
      r_sel  <= w_sel_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign bus.load_ready = ~r_full;
  assign bus.segmentos  = r_seg;
  assign bus.sel_seg    = r_sel;
  assign bus.frame_tick = r_tick;

endmodule

`default_nettype wire
